hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of both stall counters.
REQ-002 SHALL have i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have i_id_rs1  input  5  rs1 index of instruction in ID.
REQ-005 SHALL have i_id_rs2  input  5  rs2 index of instruction in ID.
REQ-006 SHALL have i_id_rs1_used  input  1  ID instruction reads rs1.
REQ-007 SHALL have i_id_rs2_used  input  1  ID instruction reads rs2.
REQ-008 SHALL have i_id_rd  input  5  rd index of instruction in ID.
REQ-009 SHALL have i_id_reg_wen  input  1  ID instruction writes rd.
REQ-010 SHALL have i_id_load  input  1  ID instruction is a load.
REQ-011 SHALL have i_flush  input  1  taken branch/jump resolved in EX; kill IF and ID.
REQ-012 SHALL have i_mem_busy  input  1  data memory not ready; freeze pipeline.
REQ-013 SHALL have o_stall  output  1  hold PC and IF/ID register.
REQ-014 SHALL have o_bubble_idex  output  1  load NOP into ID/EX register.
REQ-015 SHALL have o_frwd_alu_op1 / o_frwd_alu_op2  output  1 each  forward MEM-stage ALU result to op1/op2.
REQ-016 SHALL have o_frwd_mem_alu_op1 / o_frwd_mem_alu_op2  output  1 each  forward WB-stage ALU result to op1/op2.
REQ-017 SHALL have o_frwd_mem_op1 / o_frwd_mem_op2  output  1 each  forward WB-stage load data to op1/op2.
REQ-018 SHALL have o_lu_stall_cnt  output  CNT_W  load-use stall cycles.
REQ-019 SHALL have o_mem_stall_cnt  output  CNT_W  memory-busy freeze cycles.

Function
REQ-020 SHALL keep shadow registers EX{rs1,rs2,rs1_used,rs2_used,rd,wen,load}, MEM{rd,wen,load}, WB{rd,wen,load}, mirroring the pipeline.
REQ-021 SHALL, when not frozen, shift each edge: WB<=MEM, MEM<=EX, EX<=ID fields, or EX<=bubble (wen=0, load=0, used=0) when o_bubble_idex=1.
REQ-022 SHALL derive forwarding outputs combinationally from shadow registers only (no ID inputs); they apply to the instruction in EX.
REQ-023 SHALL, per operand N, treat a match as EX.rsN_used & producer.wen & producer.rd==EX.rsN & EX.rsN!=0.
REQ-024 SHALL assert o_frwd_alu_opN on MEM match with MEM.load=0.
REQ-025 SHALL, absent a qualifying MEM match, assert o_frwd_mem_opN on WB match with WB.load=1, else o_frwd_mem_alu_opN on WB match with WB.load=0.
REQ-026 SHALL keep at most one forwarding output per operand high (MEM priority over WB).
REQ-027 SHALL detect load-use when EX.load & EX.wen & EX.rd!=0 & EX.rd matches a used ID rs; assert o_stall=1 and o_bubble_idex=1 for that cycle.
REQ-028 SHALL, on i_flush=1 (busy=0), assert o_bubble_idex=1, o_stall=0, suppress load-use detection.
REQ-029 SHALL, on i_mem_busy=1, assert o_stall=1, o_bubble_idex=0, hold all shadow registers; i_flush and load-use are ignored; requester holds i_flush until busy drops.
REQ-030 SHALL use priority i_mem_busy > i_flush > load-use.
REQ-031 SHALL increment o_lu_stall_cnt each load-use stall cycle and o_mem_stall_cnt each busy cycle, saturating at all-ones.

Reset
REQ-032 SHALL, while i_rst_n=0, clear all shadow registers and counters immediately; o_stall, o_bubble_idex and all forwarding outputs then read 0 unless i_mem_busy=1.
REQ-033 SHALL, on reset mid-stall, abandon the stall; the first post-reset cycle sees an empty pipeline.

Structure
REQ-034 SHALL take REG_IDX_W=5 and REG_X0=5'd0 from shared package cpu_pkg.
REQ-035 SHALL instantiate sub-module sat_cnt (CNT_W, enable, async active-low reset) twice for the counters.

Verification
REQ-036 add x5 then sub reading x5 next -> o_frwd_alu_op1=1 in sub's EX; others 0.
REQ-037 lw x7 then add rs2=x7 -> one cycle o_stall=1, o_bubble_idex=1, o_lu_stall_cnt 0->1; next cycle o_frwd_mem_op2=1.
REQ-038 add x3 then nop then or rs1=x3 -> o_frwd_mem_alu_op1=1; rd=x0 producer -> no forwarding.
REQ-039 i_mem_busy high 3 cycles during lw/use pair -> o_stall=1 x3, shadows unchanged, o_mem_stall_cnt=3, then load-use resolves as REQ-037.
REQ-040 i_flush with load-use pending -> o_bubble_idex=1, o_stall=0, lu counter unchanged; assert i_rst_n=0 mid-busy -> all outputs 0 and counters 0 asynchronously.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared CPU constants and pipeline shadow-stage types.
// Rev    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

    // Destination-side view of an in-flight instruction.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 wen;
        logic                 load;
    } prod_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic                 rs1_used;
        logic                 rs2_used;
        prod_t                dst;
    } ex_t;

    // True when a producer writes the register a consumer operand reads (x0 never matches).
    function automatic logic opnd_match(input logic                 used,
                                        input logic [REG_IDX_W-1:0] rs,
                                        input prod_t                p);
        return used & p.wen & (p.rd == rs) & (rs != REG_X0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
// Module : sat_cnt
// Brief  : Enabled up-counter that sticks at all-ones.
// Rev    : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != '1)) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : hazard_ctrl
// Brief  : Pipeline hazard unit - forwarding select, load-use stall, flush
//          bubble and memory-busy freeze, with stall-cycle counters.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REG_IDX_W-1:0] i_id_rs1,
    input  logic [REG_IDX_W-1:0] i_id_rs2,
    input  logic                 i_id_rs1_used,
    input  logic                 i_id_rs2_used,
    input  logic [REG_IDX_W-1:0] i_id_rd,
    input  logic                 i_id_reg_wen,
    input  logic                 i_id_load,
    input  logic                 i_flush,
    input  logic                 i_mem_busy,
    output logic                 o_stall,
    output logic                 o_bubble_idex,
    output logic                 o_frwd_alu_op1,
    output logic                 o_frwd_alu_op2,
    output logic                 o_frwd_mem_alu_op1,
    output logic                 o_frwd_mem_alu_op2,
    output logic                 o_frwd_mem_op1,
    output logic                 o_frwd_mem_op2,
    output logic [CNT_W-1:0]     o_lu_stall_cnt,
    output logic [CNT_W-1:0]     o_mem_stall_cnt
);

    ex_t   r_ex;
    prod_t r_mem;
    prod_t r_wb;

    ex_t   w_id;
    logic  w_lu_hazard;
    logic  w_lu_stall;
    logic  w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;

    assign w_id = '{rs1: i_id_rs1, rs2: i_id_rs2,
                    rs1_used: i_id_rs1_used, rs2_used: i_id_rs2_used,
                    dst: '{rd: i_id_rd, wen: i_id_reg_wen, load: i_id_load}};

    // A load in EX cannot supply its data in time for a dependent op in ID.
    assign w_lu_hazard = r_ex.dst.load &
                         (opnd_match(i_id_rs1_used, i_id_rs1, r_ex.dst) |
                          opnd_match(i_id_rs2_used, i_id_rs2, r_ex.dst));

    always_comb begin
        o_stall       = 1'b0;
        o_bubble_idex = 1'b0;
        w_lu_stall    = 1'b0;
        if (i_mem_busy) begin
            o_stall = 1'b1;
        end else if (i_flush && i_rst_n) begin
            o_bubble_idex = 1'b1;
        end else if (w_lu_hazard) begin
            o_stall       = 1'b1;
            o_bubble_idex = 1'b1;
            w_lu_stall    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!i_mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex.dst;
            r_ex  <= o_bubble_idex ? '0 : w_id;
        end
    end

    // A loaded value still in MEM is not a valid source, so WB is considered instead.
    assign w_mem_m1 = opnd_match(r_ex.rs1_used, r_ex.rs1, r_mem) & ~r_mem.load;
    assign w_mem_m2 = opnd_match(r_ex.rs2_used, r_ex.rs2, r_mem) & ~r_mem.load;
    assign w_wb_m1  = opnd_match(r_ex.rs1_used, r_ex.rs1, r_wb);
    assign w_wb_m2  = opnd_match(r_ex.rs2_used, r_ex.rs2, r_wb);

    assign o_frwd_alu_op1     = w_mem_m1;
    assign o_frwd_alu_op2     = w_mem_m2;
    assign o_frwd_mem_op1     = ~w_mem_m1 & w_wb_m1 &  r_wb.load;
    assign o_frwd_mem_op2     = ~w_mem_m2 & w_wb_m2 &  r_wb.load;
    assign o_frwd_mem_alu_op1 = ~w_mem_m1 & w_wb_m1 & ~r_wb.load;
    assign o_frwd_mem_alu_op2 = ~w_mem_m2 & w_wb_m2 & ~r_wb.load;

    sat_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (w_lu_stall),
        .o_cnt   (o_lu_stall_cnt)
    );

    sat_cnt #(.CNT_W(CNT_W)) u_mem_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_mem_busy),
        .o_cnt   (o_mem_stall_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Self-checking bench for hazard_ctrl: directed vector table,
//          reset corner sequence and randomized run against a pipeline model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W = 3;
    localparam int c_sat = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       wen;
        logic       ld;
    } instr_t;

    typedef struct packed {
        instr_t     id;
        logic       fl;
        logic       bz;
        logic [7:0] exp;
        logic [2:0] lu;
        logic [2:0] mc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic id_u1, id_u2, id_wen, id_ld, flush, busy;
    logic stall, bubble, fa1, fa2, fma1, fma2, fm1, fm2;
    logic [CNT_W-1:0] lu_cnt, mem_cnt;
    logic [7:0] outv;

    int n_cmp = 0;
    int n_bad = 0;

    instr_t m_ex, m_mem, m_wb;
    int m_lu, m_mc;

    always #5 clk = ~clk;

    assign outv = {stall, bubble, fa1, fa2, fma1, fma2, fm1, fm2};

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_id_rs1           (id_rs1),
        .i_id_rs2           (id_rs2),
        .i_id_rs1_used      (id_u1),
        .i_id_rs2_used      (id_u2),
        .i_id_rd            (id_rd),
        .i_id_reg_wen       (id_wen),
        .i_id_load          (id_ld),
        .i_flush            (flush),
        .i_mem_busy         (busy),
        .o_stall            (stall),
        .o_bubble_idex      (bubble),
        .o_frwd_alu_op1     (fa1),
        .o_frwd_alu_op2     (fa2),
        .o_frwd_mem_alu_op1 (fma1),
        .o_frwd_mem_alu_op2 (fma2),
        .o_frwd_mem_op1     (fm1),
        .o_frwd_mem_op2     (fm2),
        .o_lu_stall_cnt     (lu_cnt),
        .o_mem_stall_cnt    (mem_cnt)
    );

    function automatic instr_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                                  input int rd, input bit wen, input bit ld);
        instr_t t;
        t.rs1 = rs1[4:0]; t.rs2 = rs2[4:0]; t.rd = rd[4:0];
        t.u1 = u1; t.u2 = u2; t.wen = wen; t.ld = ld;
        return t;
    endfunction

    function automatic vec_t mkv(input instr_t id, input bit fl, input bit bz,
                                 input logic [7:0] exp, input int lu, input int mc);
        vec_t v;
        v.id = id; v.fl = fl; v.bz = bz; v.exp = exp;
        v.lu = lu[2:0]; v.mc = mc[2:0];
        return v;
    endfunction

    task automatic apply(input instr_t i, input logic fl, input logic bz);
        id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd;
        id_u1 = i.u1; id_u2 = i.u2; id_wen = i.wen; id_ld = i.ld;
        flush = fl; busy = bz;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    // Source for one EX operand: {MEM alu, WB alu, WB load}, nearest qualifying producer wins.
    function automatic logic [2:0] src(input logic u, input logic [4:0] rs);
        if (!u || rs == 5'd0) return 3'b000;
        if (m_mem.wen && m_mem.rd == rs && !m_mem.ld) return 3'b100;
        if (m_wb.wen && m_wb.rd == rs) return m_wb.ld ? 3'b001 : 3'b010;
        return 3'b000;
    endfunction

    function automatic bit lu_dep(input instr_t id);
        if (!(m_ex.ld && m_ex.wen && m_ex.rd != 5'd0)) return 1'b0;
        return (id.u1 && id.rs1 == m_ex.rd) || (id.u2 && id.rs2 == m_ex.rd);
    endfunction

    initial begin
        vec_t   vt[25];
        instr_t NOP, ADD5, SUB, ADD3, ORI, ADDX0, RDX0, LW7, USE7;

        NOP   = '0;
        ADD5  = mk(1, 2, 1, 1, 5, 1, 0);
        SUB   = mk(5, 4, 1, 1, 6, 1, 0);
        ADD3  = mk(1, 0, 1, 0, 3, 1, 0);
        ORI   = mk(3, 0, 1, 0, 8, 1, 0);
        ADDX0 = mk(1, 1, 1, 1, 0, 1, 0);
        RDX0  = mk(0, 0, 1, 1, 9, 1, 0);
        LW7   = mk(1, 0, 1, 0, 7, 1, 1);
        USE7  = mk(2, 7, 1, 1, 10, 1, 0);

        vt[0]  = mkv(ADD5,  0, 0, 8'h00, 0, 0);
        vt[1]  = mkv(SUB,   0, 0, 8'h00, 0, 0);
        vt[2]  = mkv(NOP,   0, 0, 8'h20, 0, 0);
        vt[3]  = mkv(ADD3,  0, 0, 8'h00, 0, 0);
        vt[4]  = mkv(NOP,   0, 0, 8'h00, 0, 0);
        vt[5]  = mkv(ORI,   0, 0, 8'h00, 0, 0);
        vt[6]  = mkv(ADDX0, 0, 0, 8'h08, 0, 0);
        vt[7]  = mkv(RDX0,  0, 0, 8'h00, 0, 0);
        vt[8]  = mkv(NOP,   0, 0, 8'h00, 0, 0);
        vt[9]  = mkv(LW7,   0, 0, 8'h00, 0, 0);
        vt[10] = mkv(USE7,  0, 0, 8'hC0, 0, 0);
        vt[11] = mkv(USE7,  0, 0, 8'h00, 1, 0);
        vt[12] = mkv(NOP,   0, 0, 8'h01, 1, 0);
        vt[13] = mkv(LW7,   0, 0, 8'h00, 1, 0);
        vt[14] = mkv(USE7,  0, 1, 8'h80, 1, 0);
        vt[15] = mkv(USE7,  0, 1, 8'h80, 1, 1);
        vt[16] = mkv(USE7,  0, 1, 8'h80, 1, 2);
        vt[17] = mkv(USE7,  0, 0, 8'hC0, 1, 3);
        vt[18] = mkv(USE7,  0, 0, 8'h00, 2, 3);
        vt[19] = mkv(NOP,   0, 0, 8'h01, 2, 3);
        vt[20] = mkv(LW7,   0, 0, 8'h00, 2, 3);
        vt[21] = mkv(USE7,  1, 0, 8'h40, 2, 3);
        vt[22] = mkv(NOP,   0, 0, 8'h00, 2, 3);
        vt[23] = mkv(NOP,   1, 1, 8'h80, 2, 3);
        vt[24] = mkv(NOP,   0, 0, 8'h00, 2, 4);

        rst_n = 1'b0;
        apply(NOP, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        chk("reset_outputs", {8'd0, outv}, 16'd0);
        chk("reset_counters", {10'd0, lu_cnt, mem_cnt}, 16'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 25; i++) begin
            apply(vt[i].id, vt[i].fl, vt[i].bz);
            #3;
            chk($sformatf("vec%0d_out", i), {8'd0, outv}, {8'd0, vt[i].exp});
            chk($sformatf("vec%0d_cnt", i), {10'd0, lu_cnt, mem_cnt}, {10'd0, vt[i].lu, vt[i].mc});
            @(posedge clk); #1;
        end

        // Reset asserted while frozen with a load-use pair pending.
        apply(LW7, 0, 0);
        @(posedge clk); #1;
        apply(USE7, 0, 1);
        #3;
        chk("rst_pre_busy", {8'd0, outv}, 16'h0080);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_cnt", {10'd0, lu_cnt, mem_cnt}, 16'd0);
        chk("rst_async_out", {9'd0, outv[6:0]}, 16'd0);
        chk("rst_async_stall", {15'd0, stall}, 16'd1);
        busy = 1'b0;
        #1;
        chk("rst_idle_out", {8'd0, outv}, 16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(USE7, 0, 0);
        #3;
        chk("post_rst_empty", {8'd0, outv}, 16'd0);
        chk("post_rst_cnt", {10'd0, lu_cnt, mem_cnt}, 16'd0);
        @(posedge clk); #1;

        rst_n = 1'b0;
        apply(NOP, 0, 0);
        m_ex = '0; m_mem = '0; m_wb = '0; m_lu = 0; m_mc = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int c = 0; c < 600; c++) begin
            instr_t id;
            logic fl, bz, st, bb, lu;
            logic [2:0] s1, s2;
            logic [7:0] exp;
            id = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0);
            fl = ($urandom_range(0, 9) == 0);
            bz = ($urandom_range(0, 6) == 0);
            apply(id, fl, bz);
            #3;
            lu = !bz && !fl && lu_dep(id);
            st = bz || lu;
            bb = !bz && (fl || lu);
            s1 = src(m_ex.u1, m_ex.rs1);
            s2 = src(m_ex.u2, m_ex.rs2);
            exp = {st, bb, s1[2], s2[2], s1[1], s2[1], s1[0], s2[0]};
            chk($sformatf("rand%0d_out", c), {8'd0, outv}, {8'd0, exp});
            chk($sformatf("rand%0d_cnt", c), {10'd0, lu_cnt, mem_cnt},
                {10'd0, m_lu[CNT_W-1:0], m_mc[CNT_W-1:0]});
            if (bz) begin
                if (m_mc < c_sat) m_mc++;
            end else begin
                if (lu && m_lu < c_sat) m_lu++;
                m_wb  = m_mem;
                m_mem = m_ex;
                m_ex  = bb ? '0 : id;
            end
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
